// File: rtl/rv32i_types.sv
// Shared front-end types: prediction-queue entry layout and memory read-mask encodings.
package rv32i_types;

   localparam logic [3:0] RMASK_READ = 4'hf;
   localparam logic [3:0] RMASK_IDLE = 4'h0;

   typedef struct packed {
      logic [31:0] pc;
      logic        pred_taken;
      logic [31:0] pred_target;
      logic [31:0] data;
      logic        done;
   } fetch_pq_entry_t;

endpackage

// File: rtl/fetch_pred_queue.sv
// Circular buffer of in-flight fetches: allocation at tail, in-order fill at resp_ptr, drain at head.
module fetch_pred_queue
   import rv32i_types::*;
#(
   parameter int  DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            enq_i,
   input  logic [31:0]     enq_pc_i,
   input  logic            enq_taken_i,
   input  logic [31:0]     enq_target_i,
   input  logic            fill_i,
   input  logic [31:0]     fill_data_i,
   input  logic            deq_i,
   output fetch_pq_entry_t head_o,
   output logic            head_is_fill_o,
   output logic [CW-1:0]   live_cnt_o
);

   fetch_pq_entry_t entries_q [DEPTH];
   logic [PW-1:0]   head_ptr_q;
   logic [PW-1:0]   tail_ptr_q;
   logic [PW-1:0]   resp_ptr_q;
   logic [CW-1:0]   live_cnt_q;

   assign head_o         = entries_q[head_ptr_q];
   assign head_is_fill_o = (resp_ptr_q == head_ptr_q) && (live_cnt_q != CW'(0));
   assign live_cnt_o     = live_cnt_q;

   // A fill that is bypassed and dequeued in the same cycle never marks its slot done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_ptr_q <= PW'(0);
         tail_ptr_q <= PW'(0);
         resp_ptr_q <= PW'(0);
         live_cnt_q <= CW'(0);
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else if (flush_i) begin
         head_ptr_q <= PW'(0);
         tail_ptr_q <= PW'(0);
         resp_ptr_q <= PW'(0);
         live_cnt_q <= CW'(0);
      end else begin
         if (enq_i) begin
            entries_q[tail_ptr_q] <= '{pc: enq_pc_i, pred_taken: enq_taken_i,
                                       pred_target: enq_target_i, data: 32'd0, done: 1'b0};
            tail_ptr_q <= tail_ptr_q + PW'(1);
         end
         if (fill_i) begin
            entries_q[resp_ptr_q].data <= fill_data_i;
            entries_q[resp_ptr_q].done <= !(deq_i && (resp_ptr_q == head_ptr_q));
            resp_ptr_q <= resp_ptr_q + PW'(1);
         end
         if (deq_i) begin
            head_ptr_q <= head_ptr_q + PW'(1);
         end
         case ({enq_i, deq_i})
            2'b10:   live_cnt_q <= live_cnt_q + CW'(1);
            2'b01:   live_cnt_q <= live_cnt_q - CW'(1);
            default: live_cnt_q <= live_cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC register, read issue, stale-response drop accounting and IQ presentation.
// Define FETCH_RESP_BYPASS_EN to forward a response straight to the IQ when it fills the head entry.
module fetch_pc_gen
   import rv32i_types::*;
#(
   parameter logic [31:0] RESET_PC = 32'h1eceb000,
   parameter int          PQ_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] btb_pc,
   input  logic [31:0] btb_next_pc,
   input  logic        btb_taken,
   output logic [31:0] imem_addr,
   output logic [3:0]  imem_rmask,
   input  logic [31:0] imem_rdata,
   input  logic        imem_resp,
   output logic        iq_valid,
   input  logic        iq_ready,
   output logic [31:0] iq_inst,
   output logic [31:0] iq_pc,
   output logic        iq_pred_taken,
   output logic [31:0] iq_pred_target,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int            CW      = $clog2(PQ_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(PQ_DEPTH);

   logic [31:0]     pc_q, pc_d;
   logic [CW-1:0]   out_cnt_q, out_cnt_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]   live_cnt_s;
   logic            issue_s, fill_s, deq_s, head_is_fill_s;
   fetch_pq_entry_t head_s;

   fetch_pred_queue #(.DEPTH(PQ_DEPTH)) u_pq (
      .clk            (clk),
      .rst            (rst),
      .flush_i        (redirect_valid),
      .enq_i          (issue_s),
      .enq_pc_i       (pc_q),
      .enq_taken_i    (btb_taken),
      .enq_target_i   (btb_next_pc),
      .fill_i         (fill_s),
      .fill_data_i    (imem_rdata),
      .deq_i          (deq_s),
      .head_o         (head_s),
      .head_is_fill_o (head_is_fill_s),
      .live_cnt_o     (live_cnt_s)
   );

   // Slots are judged on start-of-cycle counts; a same-cycle dequeue does not free one.
   always_comb begin
      issue_s = rst && !redirect_valid && (live_cnt_s < DEPTH_C) && (out_cnt_q < DEPTH_C);
      fill_s  = rst && !redirect_valid && imem_resp && (drop_cnt_q == CW'(0));
   end

`ifdef FETCH_RESP_BYPASS_EN
   logic bypass_s;
   always_comb begin
      bypass_s = fill_s && head_is_fill_s;
      iq_valid = rst && !redirect_valid && (live_cnt_s != CW'(0)) && (head_s.done || bypass_s);
      iq_inst  = bypass_s ? imem_rdata : head_s.data;
   end
`else
   logic unused_head_fill_s;
   always_comb begin
      unused_head_fill_s = head_is_fill_s;
      iq_valid = rst && !redirect_valid && (live_cnt_s != CW'(0)) && head_s.done;
      iq_inst  = head_s.data;
   end
`endif

   assign deq_s          = iq_valid && iq_ready;
   assign iq_pc          = head_s.pc;
   assign iq_pred_taken  = head_s.pred_taken;
   assign iq_pred_target = head_s.pred_target;
   assign btb_pc         = pc_q;
   assign imem_addr      = pc_q;
   assign imem_rmask     = issue_s ? RMASK_READ : RMASK_IDLE;

   // Every read still in flight at a redirect becomes a response to discard.
   always_comb begin
      pc_d       = pc_q;
      out_cnt_d  = out_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (redirect_valid) begin
         pc_d       = redirect_pc;
         out_cnt_d  = imem_resp ? (out_cnt_q - CW'(1)) : out_cnt_q;
         drop_cnt_d = out_cnt_d;
      end else begin
         if (issue_s) pc_d = btb_next_pc;
         else         pc_d = pc_q;
         case ({issue_s, imem_resp})
            2'b10:   out_cnt_d = out_cnt_q + CW'(1);
            2'b01:   out_cnt_d = out_cnt_q - CW'(1);
            default: out_cnt_d = out_cnt_q;
         endcase
         if (imem_resp && (drop_cnt_q != CW'(0))) drop_cnt_d = drop_cnt_q - CW'(1);
         else                                     drop_cnt_d = drop_cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q       <= RESET_PC;
         out_cnt_q  <= CW'(0);
         drop_cnt_q <= CW'(0);
      end else begin
         pc_q       <= pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

endmodule
